// File: rtl/fmap_streamer.sv
// Captures a convolution feature map on 'done' and streams it row-major over a valid/ready port.
// Optional build macro FMAP_MAXPOOL_EN: capture a 2x2 non-overlapping max-pooled map instead.
module fmap_streamer #(
    parameter int SIZE      = 7,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 8
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic signed [WIDTH_BIT-1:0] fmapIn [0:SIZE-SIZEKer][0:SIZE-SIZEKer],
    input  logic                        done,
    output logic signed [WIDTH_BIT-1:0] dataOut,
    output logic                        valid,
    input  logic                        ready,
    output logic                        last,
    output logic                        busy,
    output logic                        overrun
);

    localparam int OUT = SIZE - SIZEKer + 1;
`ifdef FMAP_MAXPOOL_EN
    localparam int N = OUT / 2;
`else
    localparam int N = OUT;
`endif
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                        r_state;
    state_t                        w_nextState;
    logic        [CW-1:0]          r_row;
    logic        [CW-1:0]          r_col;
    logic                          r_overrun;
    logic signed [WIDTH_BIT-1:0]   r_buf    [0:N-1][0:N-1];
    logic signed [WIDTH_BIT-1:0]   w_capVal [0:N-1][0:N-1];
    logic                          w_handshake;
    logic                          w_lastPos;
    logic                          w_finish;
    logic                          w_capture;

`ifdef FMAP_MAXPOOL_EN
    function automatic logic signed [WIDTH_BIT-1:0] smax(
        input logic signed [WIDTH_BIT-1:0] a,
        input logic signed [WIDTH_BIT-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Each pooled cell covers a 2x2 window; an odd trailing row/column never feeds a window.
    for (genvar gr = 0; gr < N; gr++) begin : g_poolRow
        for (genvar gc = 0; gc < N; gc++) begin : g_poolCol
            assign w_capVal[gr][gc] = smax(smax(fmapIn[2*gr][2*gc],   fmapIn[2*gr][2*gc+1]),
                                           smax(fmapIn[2*gr+1][2*gc], fmapIn[2*gr+1][2*gc+1]));
        end
    end
`else
    for (genvar gr = 0; gr < N; gr++) begin : g_copyRow
        for (genvar gc = 0; gc < N; gc++) begin : g_copyCol
            assign w_capVal[gr][gc] = fmapIn[gr][gc];
        end
    end
`endif

    assign w_handshake = (r_state == STREAM) && ready;
    assign w_lastPos   = (r_row == LAST_IDX) && (r_col == LAST_IDX);
    assign w_finish    = w_handshake && w_lastPos;
    // A done landing on the final handshake chains straight into the next map.
    assign w_capture   = done && ((r_state == IDLE) || w_finish);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (done) begin
                    w_nextState = STREAM;
                end
            end
            STREAM: begin
                if (w_finish && !done) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_capture) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_handshake) begin
            if (r_col == LAST_IDX) begin
                r_col <= '0;
                r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_overrun <= 1'b0;
        end else if (done && (r_state == STREAM) && !w_finish) begin
            r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
        end else if (w_capture) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_buf[r][c] <= w_capVal[r][c];
                end
            end
        end
    end

    assign valid   = (r_state == STREAM);
    assign busy    = (r_state != IDLE);
    assign last    = valid && w_lastPos;
    assign overrun = r_overrun;
    assign dataOut = valid ? r_buf[r_row][r_col] : '0;

endmodule

// File: tb/tb_fmap_streamer.sv
// Directed self-checking bench for fmap_streamer; follows FMAP_MAXPOOL_EN to pick pooled or plain checks.
module tb_fmap_streamer;

    localparam int OUT = 5;
`ifdef FMAP_MAXPOOL_EN
    localparam int N = 2;
`else
    localparam int N = 5;
`endif
    localparam int NUM = N * N;

    logic              clock;
    logic              nreset;
    logic signed [7:0] fmapIn [0:OUT-1][0:OUT-1];
    logic              done;
    logic signed [7:0] dataOut;
    logic              valid;
    logic              ready;
    logic              last;
    logic              busy;
    logic              overrun;

    int checks;
    int errors;

    typedef struct {
        logic ready;
        int   expData;
        logic expLast;
    } vec_t;

    vec_t vecs [0:2*NUM-1];

    fmap_streamer #(.SIZE(7), .SIZEKer(3), .WIDTH_BIT(8)) dut (
        .clock   (clock),
        .nreset  (nreset),
        .fmapIn  (fmapIn),
        .done    (done),
        .dataOut (dataOut),
        .valid   (valid),
        .ready   (ready),
        .last    (last),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic loadRamp(input int offset);
        for (int r = 0; r < OUT; r++)
            for (int c = 0; c < OUT; c++)
                fmapIn[r][c] = 8'(5 * r + c + offset);
    endtask

    task automatic loadConst(input int v);
        for (int r = 0; r < OUT; r++)
            for (int c = 0; c < OUT; c++)
                fmapIn[r][c] = 8'(v);
    endtask

    task automatic applyStimulus(input logic d, input logic rdy);
        done  = d;
        ready = rdy;
    endtask

    task automatic doReset();
        nreset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #12;
        nreset = 1'b1;
        tick();
    endtask

    // Pulses done for one edge; the map is expected to show up right after that edge.
    task automatic capture();
        applyStimulus(1'b1, 1'b1);
        tick();
        done = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nreset = 1'b1;
        loadRamp(0);
        doReset();

        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_last", int'(last), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        checkOutput("reset_data", int'(dataOut), 0);

`ifndef FMAP_MAXPOOL_EN
        for (int k = 0; k < 2 * NUM; k++) begin
            vecs[k].ready   = (k % 2 == 1);
            vecs[k].expData = k / 2;
            vecs[k].expLast = (k / 2 == NUM - 1);
        end

        // Full-rate stream of the ramp map.
        applyStimulus(1'b1, 1'b1);
        checkOutput("valid_same_cycle_as_done", int'(valid), 0);
        tick();
        done = 1'b0;
        for (int e = 0; e < NUM; e++) begin
            checkOutput($sformatf("ramp_valid_%0d", e), int'(valid), 1);
            checkOutput($sformatf("ramp_data_%0d", e), int'(dataOut), e);
            checkOutput($sformatf("ramp_last_%0d", e), int'(last), int'(e == NUM - 1));
            tick();
        end
        checkOutput("ramp_end_valid", int'(valid), 0);
        checkOutput("ramp_end_busy", int'(busy), 0);

        // Back-pressure: ready alternates, every element must stall once and then advance.
        capture();
        for (int k = 0; k < 2 * NUM; k++) begin
            ready = vecs[k].ready;
            #1;
            checkOutput($sformatf("bp_data_%0d", k), int'(dataOut), vecs[k].expData);
            checkOutput($sformatf("bp_last_%0d", k), int'(last), int'(vecs[k].expLast));
            checkOutput($sformatf("bp_valid_%0d", k), int'(valid), 1);
            tick();
        end
        checkOutput("bp_end_valid", int'(valid), 0);

        // A done mid-stream is dropped and flags overrun.
        capture();
        for (int e = 0; e < NUM; e++) begin
            if (e == 10) begin
                loadRamp(60);
                done = 1'b1;
            end else begin
                done = 1'b0;
            end
            checkOutput($sformatf("ovr_data_%0d", e), int'(dataOut), e);
            checkOutput($sformatf("ovr_flag_%0d", e), int'(overrun), int'(e > 10));
            tick();
        end
        done = 1'b0;
        checkOutput("ovr_sticky", int'(overrun), 1);
        checkOutput("ovr_end_valid", int'(valid), 0);

        // done on the last handshake chains into a new map with no gap.
        doReset();
        loadRamp(0);
        capture();
        for (int e = 0; e < NUM; e++) begin
            if (e == NUM - 1) begin
                loadConst(7);
                done = 1'b1;
            end
            checkOutput($sformatf("chain_data_%0d", e), int'(dataOut), e);
            tick();
        end
        done = 1'b0;
        for (int e = 0; e < NUM; e++) begin
            checkOutput($sformatf("chain2_valid_%0d", e), int'(valid), 1);
            checkOutput($sformatf("chain2_busy_%0d", e), int'(busy), 1);
            checkOutput($sformatf("chain2_data_%0d", e), int'(dataOut), 7);
            checkOutput($sformatf("chain2_last_%0d", e), int'(last), int'(e == NUM - 1));
            checkOutput($sformatf("chain2_overrun_%0d", e), int'(overrun), 0);
            tick();
        end
        checkOutput("chain2_end_busy", int'(busy), 0);

        // Reset mid-stream clears everything immediately.
        loadRamp(0);
        capture();
        for (int e = 0; e < 12; e++) begin
            done = (e == 5);
            tick();
        end
        done = 1'b0;
        checkOutput("rst_pre_data", int'(dataOut), 12);
        checkOutput("rst_pre_overrun", int'(overrun), 1);
        nreset = 1'b0;
        #1;
        checkOutput("rst_mid_valid", int'(valid), 0);
        checkOutput("rst_mid_overrun", int'(overrun), 0);
        checkOutput("rst_mid_busy", int'(busy), 0);
        checkOutput("rst_mid_data", int'(dataOut), 0);
        checkOutput("rst_mid_last", int'(last), 0);
        #2;
        nreset = 1'b1;
        tick();
        checkOutput("rst_idle_valid", int'(valid), 0);
        loadRamp(50);
        capture();
        for (int e = 0; e < 3; e++) begin
            checkOutput($sformatf("rst_restart_data_%0d", e), int'(dataOut), 50 + e);
            tick();
        end
`else
        // Pooled ramp map: maxima of each 2x2 window.
        vecs[0] = '{1'b1, 6, 1'b0};
        vecs[1] = '{1'b1, 8, 1'b0};
        vecs[2] = '{1'b1, 16, 1'b0};
        vecs[3] = '{1'b1, 18, 1'b1};
        capture();
        for (int k = 0; k < NUM; k++) begin
            ready = vecs[k].ready;
            checkOutput($sformatf("pool_valid_%0d", k), int'(valid), 1);
            checkOutput($sformatf("pool_data_%0d", k), int'(dataOut), vecs[k].expData);
            checkOutput($sformatf("pool_last_%0d", k), int'(last), int'(vecs[k].expLast));
            tick();
        end
        checkOutput("pool_end_busy", int'(busy), 0);

        // Negative values: the signed maximum of {-3,-1,-3,-3} is -1.
        loadConst(-3);
        fmapIn[0][1] = -8'sd1;
        capture();
        checkOutput("pool_neg_first", int'(dataOut), -1);
        tick();
        checkOutput("pool_neg_second", int'(dataOut), -3);
        tick();
        tick();
        checkOutput("pool_neg_last", int'(last), 1);
        tick();
        checkOutput("pool_neg_end_valid", int'(valid), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
